// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-add multiplier with START/BUSY/DONE handshake
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               SIGNED_MODE,
  input  logic [WIDTH-1:0]   INPUT1,
  input  logic [WIDTH-1:0]   INPUT2,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0]   OUT
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t             state;
  logic [WIDTH:0]     mcand;
  logic [WIDTH:0]     mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               negate;

  logic [WIDTH:0]     ext1;
  logic [WIDTH:0]     ext2;
  logic [WIDTH:0]     mag1;
  logic [WIDTH:0]     mag2;
  logic               cap_neg;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result_next;
  logic               last_iter;

  // Operand magnitudes and sign for capture; one extra bit keeps |most negative| exact
  always_comb begin
    ext1    = {SIGNED_MODE & INPUT1[WIDTH-1], INPUT1};
    ext2    = {SIGNED_MODE & INPUT2[WIDTH-1], INPUT2};
    mag1    = (SIGNED_MODE && INPUT1[WIDTH-1]) ? -ext1 : ext1;
    mag2    = (SIGNED_MODE && INPUT2[WIDTH-1]) ? -ext2 : ext2;
    cap_neg = SIGNED_MODE & (INPUT1[WIDTH-1] ^ INPUT2[WIDTH-1]);
  end

  // One shift-add step; the final step also feeds the signed result directly
  always_comb begin
    addend      = mplier[0] ? ({{(WIDTH-1){1'b0}}, mcand} << cnt) : '0;
    acc_next    = acc + addend;
    result_next = negate ? -acc_next : acc_next;
    last_iter   = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      negate <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            state  <= FINISH;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            RESULT <= result_next;
          end
        end
        default: begin
          // IDLE and FINISH both accept a new request; FINISH allows back-to-back
          DONE <= 1'b0;
          if (START) begin
            state  <= CALC;
            BUSY   <= 1'b1;
            RESULT <= '0;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= mag1;
            mplier <= mag2;
            negate <= cap_neg;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign OUT = RESULT[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier at WIDTH 8 and 16
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8, out8;
  logic [15:0] res8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16, out16;
  logic [31:0] res16;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst), .START(start8), .SIGNED_MODE(sm8),
    .INPUT1(a8), .INPUT2(b8), .BUSY(busy8), .DONE(done8),
    .RESULT(res8), .OUT(out8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET(rst), .START(start16), .SIGNED_MODE(sm16),
    .INPUT1(a16), .INPUT2(b16), .BUSY(busy16), .DONE(done16),
    .RESULT(res16), .OUT(out16)
  );

  int compared   = 0;
  int mismatched = 0;
  int dones8     = 0;
  int dones16    = 0;
  logic [15:0] q8[$];
  logic [31:0] q16[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic
  function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
    longint x, y, p;
    if (w == 8) begin
      x = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      y = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
    end else begin
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
    end
    p = x * y;
    return (w == 8) ? {16'h0, p[15:0]} : p[31:0];
  endfunction

  // Monitor for the 8-bit unit
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && done8) begin
      dones8++;
      check("busy_with_done8", {63'd0, busy8}, 64'd0);
      if (q8.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done8: got DONE with result 'h%0h, expected none", res8);
      end else begin
        e = q8.pop_front();
        check("result8", {48'd0, res8}, {48'd0, e});
        check("out8", {56'd0, out8}, {56'd0, e[7:0]});
      end
    end
  end

  // Monitor for the 16-bit unit
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && done16) begin
      dones16++;
      check("busy_with_done16", {63'd0, busy16}, 64'd0);
      if (q16.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done16: got DONE with result 'h%0h, expected none", res16);
      end else begin
        e = q16.pop_front();
        check("result16", {32'd0, res16}, {32'd0, e});
        check("out16", {48'd0, out16}, {48'd0, e[15:0]});
      end
    end
  end

  // Issue one operation, check latency, BUSY length and a single DONE pulse
  task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                    input logic [31:0] exp, input bit disturb);
    int cyc, bcnt, d0;
    @(negedge clk);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = s; start8 = 1'b1;
      q8.push_back(exp[15:0]);
      d0 = dones8;
    end else begin
      a16 = a; b16 = b; sm16 = s; start16 = 1'b1;
      q16.push_back(exp);
      d0 = dones16;
    end
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start16 = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if ((w == 8) ? done8 : done16) break;
      if ((w == 8) ? busy8 : busy16) bcnt++;
      if (disturb && w == 8) begin
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        sm8    = 1'($urandom_range(0, 1));
        start8 = (cyc == 3);
      end
    end
    check("done_latency", 64'(cyc), 64'(w + 1));
    check("busy_cycles", 64'(bcnt), 64'(w));
    repeat (3) @(negedge clk);
    check("done_pulses", 64'(((w == 8) ? dones8 : dones16) - d0), 64'd1);
  endtask

  initial begin
    int cyc, d0;
    logic [15:0] ra, rb;
    logic        rs;

    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy8", {63'd0, busy8}, 64'd0);
    check("reset_done8", {63'd0, done8}, 64'd0);
    check("reset_result8", {48'd0, res8}, 64'd0);
    check("reset_out8", {56'd0, out8}, 64'd0);
    check("reset_busy16", {63'd0, busy16}, 64'd0);
    check("reset_result16", {32'd0, res16}, 64'd0);
    rst = 1'b0;

    // Directed vectors with hand-derived products
    op(8, 16'd5,    16'd6,    1'b0, 32'h001E, 1'b0);
    op(8, 16'hFF,   16'h02,   1'b0, 32'h01FE, 1'b0);
    op(8, 16'hFF,   16'hFF,   1'b0, 32'hFE01, 1'b0);
    op(8, 16'hFD,   16'h07,   1'b1, 32'hFFEB, 1'b0);
    op(8, 16'h80,   16'h80,   1'b1, 32'h4000, 1'b0);
    op(8, 16'h80,   16'h01,   1'b1, 32'hFF80, 1'b0);
    op(8, 16'h00,   16'hFB,   1'b1, 32'h0000, 1'b0);
    op(8, 16'h00,   16'h00,   1'b0, 32'h0000, 1'b0);
    op(16, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b0);
    op(16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0);

    // START pulse and operand churn during CALC must not disturb the product
    op(8, 16'd12, 16'd11, 1'b0, 32'd132, 1'b1);
    op(8, 16'hF6, 16'd9,  1'b1, 32'hFFA6, 1'b1);

    // START held through FINISH: 15*15 then 10*10 with no idle gap
    @(negedge clk);
    a8 = 8'd15; b8 = 8'd15; sm8 = 1'b0; start8 = 1'b1;
    q8.push_back(16'd225);
    q8.push_back(16'd100);
    d0 = dones8;
    @(posedge clk);
    #1;
    a8 = 8'd10; b8 = 8'd10;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done8) break;
    end
    check("b2b_first_latency", 64'(cyc), 64'd9);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    @(negedge clk);
    check("b2b_no_idle_busy", {63'd0, busy8}, 64'd1);
    cyc = 1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done8) break;
    end
    check("b2b_second_latency", 64'(cyc), 64'd9);
    repeat (3) @(negedge clk);
    check("b2b_done_pulses", 64'(dones8 - d0), 64'd2);

    // RESET mid-CALC aborts with no DONE
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd9; sm8 = 1'b0; start8 = 1'b1;
    d0 = dones8;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, busy8}, 64'd0);
    check("abort_result", {48'd0, res8}, 64'd0);
    check("abort_done", {63'd0, done8}, 64'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", 64'(dones8 - d0), 64'd0);
    op(8, 16'd3, 16'd3, 1'b0, 32'd9, 1'b0);

    // Random vectors against the reference product
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      op(8, ra, rb, rs, ref_prod(8, ra, rb, rs), 1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      op(16, ra, rb, rs, ref_prod(16, ra, rb, rs), 1'b0);
    end

    check("queue8_drained", 64'(q8.size()), 64'd0);
    check("queue16_drained", 64'(q16.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
